// File: rtl/fwnoc_pkg.sv
// Shared definitions for the fwnoc traffic generator: header field layout,
// generator states and the payload LFSR polynomial with its step function.
package fwnoc_pkg;

    localparam int COORD_W       = 4;
    localparam int LEN_W         = 8;
    localparam int SEQ_W         = 8;
    localparam int HDR_DST_X_LSB = 28;
    localparam int HDR_DST_Y_LSB = 24;
    localparam int HDR_SRC_X_LSB = 20;
    localparam int HDR_SRC_Y_LSB = 16;
    localparam int HDR_LEN_LSB   = 8;
    localparam int HDR_SEQ_LSB   = 0;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [LEN_W-1:0]   len_t;
    typedef logic [SEQ_W-1:0]   seq_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_GAP
    } state_t;

    function automatic logic [31:0] hdr_flit(input coord_t dx, input coord_t dy,
                                             input coord_t sx, input coord_t sy,
                                             input len_t len, input seq_t seq);
        return (32'(dx)  << HDR_DST_X_LSB) | (32'(dy)  << HDR_DST_Y_LSB) |
               (32'(sx)  << HDR_SRC_X_LSB) | (32'(sy)  << HDR_SRC_Y_LSB) |
               (32'(len) << HDR_LEN_LSB)   | (32'(seq) << HDR_SEQ_LSB);
    endfunction

    // Right-shifting Galois step; the polynomial carries the x^32 tap in bit 31.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/fwnoc_lfsr32.sv
// 32-bit Galois LFSR for generator payloads; a zero seed is forced to 1 so
// the register never locks up.
module fwnoc_lfsr32
    import fwnoc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        advance,
    output logic [31:0] value
);

    logic [31:0] value_q;
    logic [31:0] value_d;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = (seed == 32'h0) ? 32'h1 : seed;
        end else if (advance) begin
            value_d = lfsr_next(value_q);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            value_q <= 32'h1;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/fwnoc_traffic_gen.sv
// Packet source for a 32-bit ready/valid router port: header + payload flits,
// with an idle gap between packets. FWNOC_TRAFFIC_GEN_LFSR_EN selects LFSR payloads.
module fwnoc_traffic_gen
    import fwnoc_pkg::*;
#(
    parameter logic [3:0] X_ID = 4'd0,
    parameter logic [3:0] Y_ID = 4'd0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] pkt_count,
    input  logic [7:0]  pkt_len,
    input  logic [3:0]  dst_x,
    input  logic [3:0]  dst_y,
    input  logic [7:0]  gap,
    input  logic [31:0] seed,
    output logic [31:0] o_dat,
    output logic        o_valid,
    input  logic        o_ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] pkts_sent
);

    state_t      state_q, state_d;
    seq_t        seq_q, seq_d;
    len_t        idx_q, idx_d;
    len_t        len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    coord_t      dx_q, dx_d, dy_q, dy_d;
    logic [7:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
    logic [15:0] pkts_sent_q, pkts_sent_d;
    logic [31:0] o_dat_q, o_dat_d;
    logic        o_valid_q, o_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        zero_pend_q, zero_pend_d;

    logic        xfer;
    logic        start_acc;
    logic        end_pkt;
    logic [31:0] pay_first;
    logic [31:0] pay_next;

    assign xfer      = o_valid_q && o_ready;
    assign start_acc = (state_q == ST_IDLE) && !zero_pend_q && start;

`ifdef FWNOC_TRAFFIC_GEN_LFSR_EN
    logic [31:0] lfsr_value;
    logic        lfsr_adv;

    assign lfsr_adv = (state_q == ST_PAYLOAD) && xfer;

    fwnoc_lfsr32 u_lfsr (
        .clock   (clock),
        .reset   (reset),
        .load    (start_acc),
        .seed    (seed),
        .advance (lfsr_adv),
        .value   (lfsr_value)
    );

    // o_dat is registered, so the flit after the current one needs the next state.
    assign pay_first = lfsr_value;
    assign pay_next  = lfsr_next(lfsr_value);
`else
    logic unused_seed;
    assign unused_seed = ^seed;
    assign pay_first   = {seq_q, 16'h0, 8'h00};
    assign pay_next    = {seq_q, 16'h0, idx_q + 8'd1};
`endif

    always_comb begin
        state_d     = state_q;
        seq_d       = seq_q;
        idx_d       = idx_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        gap_d       = gap_q;
        gap_cnt_d   = gap_cnt_q;
        pkts_sent_d = pkts_sent_q;
        o_dat_d     = o_dat_q;
        o_valid_d   = o_valid_q;
        busy_d      = busy_q;
        zero_pend_d = 1'b0;
        done_d      = 1'b0;
        end_pkt     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (zero_pend_q) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else if (start) begin
                    cnt_d       = pkt_count;
                    len_d       = pkt_len;
                    dx_d        = dst_x;
                    dy_d        = dst_y;
                    gap_d       = gap;
                    seq_d       = '0;
                    pkts_sent_d = '0;
                    busy_d      = 1'b1;
                    if (pkt_count == 16'd0) begin
                        zero_pend_d = 1'b1;
                    end else begin
                        state_d   = ST_HDR;
                        o_valid_d = 1'b1;
                        o_dat_d   = hdr_flit(dst_x, dst_y, X_ID, Y_ID, pkt_len, 8'h00);
                    end
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    if (len_q == 8'd0) begin
                        end_pkt = 1'b1;
                    end else begin
                        state_d = ST_PAYLOAD;
                        idx_d   = 8'd0;
                        o_dat_d = pay_first;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    if (idx_q == len_q - 8'd1) begin
                        end_pkt = 1'b1;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        o_dat_d = pay_next;
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q <= 8'd1) begin
                    state_d   = ST_HDR;
                    o_valid_d = 1'b1;
                    o_dat_d   = hdr_flit(dx_q, dy_q, X_ID, Y_ID, len_q, seq_q);
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (end_pkt) begin
            pkts_sent_d = (pkts_sent_q == 16'hFFFF) ? pkts_sent_q : pkts_sent_q + 16'd1;
            seq_d       = seq_q + 8'd1;
            if (pkts_sent_q + 16'd1 == cnt_q) begin
                state_d   = ST_IDLE;
                o_valid_d = 1'b0;
                busy_d    = 1'b0;
                done_d    = 1'b1;
            end else if (gap_q == 8'd0) begin
                state_d   = ST_HDR;
                o_valid_d = 1'b1;
                o_dat_d   = hdr_flit(dx_q, dy_q, X_ID, Y_ID, len_q, seq_q + 8'd1);
            end else begin
                state_d   = ST_GAP;
                o_valid_d = 1'b0;
                gap_cnt_d = gap_q;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            seq_q       <= '0;
            idx_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            dx_q        <= '0;
            dy_q        <= '0;
            gap_q       <= '0;
            gap_cnt_q   <= '0;
            pkts_sent_q <= '0;
            o_dat_q     <= '0;
            o_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            zero_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            seq_q       <= seq_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            gap_q       <= gap_d;
            gap_cnt_q   <= gap_cnt_d;
            pkts_sent_q <= pkts_sent_d;
            o_dat_q     <= o_dat_d;
            o_valid_q   <= o_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            zero_pend_q <= zero_pend_d;
        end
    end

    assign o_dat     = o_dat_q;
    assign o_valid   = o_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pkts_sent = pkts_sent_q;

endmodule

// File: tb/tb_fwnoc_traffic_gen.sv
// Directed bench for fwnoc_traffic_gen; a negedge monitor logs accepted flits
// and checks that stalled flits hold steady.
module tb_fwnoc_traffic_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic [15:0] pkt_count = '0;
    logic [7:0]  pkt_len = '0;
    logic [3:0]  dst_x = '0;
    logic [3:0]  dst_y = '0;
    logic [7:0]  gap = '0;
    logic [31:0] seed = '0;
    logic [31:0] o_dat;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic        busy;
    logic        done;
    logic [15:0] pkts_sent;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int start_edge = 0;
    int done_cyc = 0;
    logic [31:0] flits[$];
    int          fcyc[$];
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [31:0] prev_dat = '0;

    fwnoc_traffic_gen #(.X_ID(4'd0), .Y_ID(4'd0)) dut (
        .clock     (clk),
        .reset     (rst_n),
        .start     (start),
        .pkt_count (pkt_count),
        .pkt_len   (pkt_len),
        .dst_x     (dst_x),
        .dst_y     (dst_y),
        .gap       (gap),
        .seed      (seed),
        .o_dat     (o_dat),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .busy      (busy),
        .done      (done),
        .pkts_sent (pkts_sent)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected payload word k of a run (k counts payload flits across packets).
    function automatic logic [31:0] pay(input logic [7:0] sq, input logic [7:0] i, input int k);
`ifdef FWNOC_TRAFFIC_GEN_LFSR_EN
        logic [31:0] s;
        s = 32'h1;
        for (int j = 0; j < k; j++) s = (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
        return s;
`else
        return {sq, 16'h0, i};
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_v = 1'b0;
        end else begin
            if (prev_v && !prev_r) begin
                chk("stall_valid", {31'b0, o_valid}, 32'd1);
                chk("stall_dat", o_dat, prev_dat);
            end
            if (o_valid && o_ready) begin
                flits.push_back(o_dat);
                fcyc.push_back(cyc);
            end
            prev_v   = o_valid;
            prev_r   = o_ready;
            prev_dat = o_dat;
        end
    end

    task automatic run(input logic [15:0] cnt, input logic [7:0] len, input logic [7:0] g,
                       input logic [31:0] sd, input bit tog);
        logic seen;
        flits.delete();
        fcyc.delete();
        pkt_count = cnt; pkt_len = len; dst_x = 4'd2; dst_y = 4'd1; gap = g; seed = sd;
        start = 1'b1;
        start_edge = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0;
        pkt_count = 16'd7; pkt_len = 8'h55; dst_x = 4'hF; dst_y = 4'hE; gap = 8'd9; seed = 32'hDEAD_BEEF;
        if (cnt != 16'd0) chk("busy_after_start", {31'b0, busy}, 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            @(posedge clk); #1;
            if (done) begin
                seen = 1'b1;
                done_cyc = cyc;
            end else if (tog) begin
                o_ready = ~o_ready;
            end
        end
        chk("done_seen", {31'b0, seen}, 32'd1);
        o_ready = 1'b1;
    endtask

    initial begin
        logic [31:0] exp8 [8];
        logic [31:0] exp3 [3];

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_o_dat", o_dat, 32'h0);
        chk("rst_o_valid", {31'b0, o_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_pkts_sent", {16'b0, pkts_sent}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two packets of three payload flits, back-to-back.
        exp8[0] = 32'h2100_0300; exp8[1] = pay(8'd0, 8'd0, 0);
        exp8[2] = pay(8'd0, 8'd1, 1); exp8[3] = pay(8'd0, 8'd2, 2);
        exp8[4] = 32'h2100_0301; exp8[5] = pay(8'd1, 8'd0, 3);
        exp8[6] = pay(8'd1, 8'd1, 4); exp8[7] = pay(8'd1, 8'd2, 5);
        run(16'd2, 8'd3, 8'd0, 32'h0, 1'b0);
        chk("t1_nflits", flits.size(), 32'd8);
        for (int i = 0; i < 8 && i < flits.size(); i++) chk($sformatf("t1_flit%0d", i), flits[i], exp8[i]);
        if (fcyc.size() == 8) begin
            chk("t1_first_cyc", fcyc[0] - start_edge, 32'd0);
            chk("t1_last_cyc", fcyc[7] - start_edge, 32'd7);
        end
        chk("t1_done_cyc", done_cyc - start_edge, 32'd8);
        chk("t1_busy_at_done", {31'b0, busy}, 32'd0);
        chk("t1_pkts_sent", {16'b0, pkts_sent}, 32'd2);
        @(posedge clk); #1;
        chk("t1_done_pulse", {31'b0, done}, 32'd0);

        // Same run with o_ready toggling; the monitor checks stall stability.
        run(16'd2, 8'd3, 8'd0, 32'h0, 1'b1);
        chk("t2_nflits", flits.size(), 32'd8);
        for (int i = 0; i < 8 && i < flits.size(); i++) chk($sformatf("t2_flit%0d", i), flits[i], exp8[i]);
        chk("t2_pkts_sent", {16'b0, pkts_sent}, 32'd2);
        @(posedge clk); #1;

        // Header-only packets with a 4-cycle gap.
        exp3[0] = 32'h2100_0000; exp3[1] = 32'h2100_0001; exp3[2] = 32'h2100_0002;
        run(16'd3, 8'd0, 8'd4, 32'h0, 1'b0);
        chk("t3_nflits", flits.size(), 32'd3);
        for (int i = 0; i < 3 && i < flits.size(); i++) chk($sformatf("t3_flit%0d", i), flits[i], exp3[i]);
        if (fcyc.size() == 3) begin
            chk("t3_gap01", fcyc[1] - fcyc[0], 32'd5);
            chk("t3_gap12", fcyc[2] - fcyc[1], 32'd5);
            chk("t3_done_cyc", done_cyc - fcyc[2], 32'd1);
        end
        chk("t3_pkts_sent", {16'b0, pkts_sent}, 32'd3);

        // Zero packets: no flits, done at N+2, and a start in the done cycle is accepted.
        run(16'd0, 8'd3, 8'd0, 32'h0, 1'b0);
        chk("t4_nflits", flits.size(), 32'd0);
        chk("t4_done_cyc", done_cyc - start_edge, 32'd1);
        chk("t4_pkts_sent", {16'b0, pkts_sent}, 32'd0);
        run(16'd1, 8'd0, 8'd0, 32'h0, 1'b0);
        chk("t4b_done_cyc", done_cyc - start_edge, 32'd1);
        chk("t4b_pkts_sent", {16'b0, pkts_sent}, 32'd1);

        // Reset during payload flit 1, then a clean restart.
        pkt_count = 16'd2; pkt_len = 8'd3; dst_x = 4'd2; dst_y = 4'd1; gap = 8'd0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_payload1", o_dat, pay(8'd0, 8'd1, 1));
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", {31'b0, o_valid}, 32'd0);
        chk("t5_rst_dat", o_dat, 32'h0);
        chk("t5_rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(16'd1, 8'd1, 8'd0, 32'h0, 1'b0);
        chk("t5_nflits", flits.size(), 32'd2);
        if (flits.size() == 2) begin
            chk("t5_hdr", flits[0], 32'h2100_0100);
            chk("t5_pay", flits[1], pay(8'd0, 8'd0, 0));
            chk("t5_first_cyc", fcyc[0] - start_edge, 32'd0);
        end
        chk("t5_pkts_sent", {16'b0, pkts_sent}, 32'd1);

`ifdef FWNOC_TRAFFIC_GEN_LFSR_EN
        // LFSR payloads from seed 0 (state 1), then a reload with a new seed.
        exp8[0] = 32'h2100_0200; exp8[1] = 32'h0000_0001; exp8[2] = 32'h8020_0003;
        exp8[3] = 32'h2100_0201; exp8[4] = 32'hC030_0002; exp8[5] = 32'h6018_0001;
        run(16'd2, 8'd2, 8'd0, 32'h0, 1'b0);
        chk("t6_nflits", flits.size(), 32'd6);
        for (int i = 0; i < 6 && i < flits.size(); i++) chk($sformatf("t6_flit%0d", i), flits[i], exp8[i]);
        run(16'd1, 8'd1, 8'd0, 32'h1234_5678, 1'b0);
        chk("t6_nflits_reload", flits.size(), 32'd2);
        if (flits.size() == 2) chk("t6_reload", flits[1], 32'h1234_5678);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
